multicycle_control_fsm: RTL

- Multicycle sequencer for the 4-bit-opcode RISC core. It steps each instruction through fetch, decode, execute, memory and writeback.
- It drives the PC, IR, register-file, memory and ALU-mux enables, and generates the 2-bit ALU operation code.
- It sits between the instruction register and the datapath, and handshakes with a variable-latency unified memory.

---
 rtl/multicycle_control_fsm_pkg.sv | 94 +++++++++
 rtl/multicycle_control_fsm_mem_wait_timer.sv | 35 +++
 rtl/multicycle_control_fsm.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_fsm_pkg.sv
// Shared definitions for the multicycle sequencer: opcodes, ALU codes,
// state encodings, mux selects and the opcode classification helpers.
package multicycle_control_fsm_pkg;

    // Opcodes of the 4-bit ISA
    localparam logic [3:0] OP_ADD  = 4'd1;
    localparam logic [3:0] OP_SUB  = 4'd2;
    localparam logic [3:0] OP_AND  = 4'd3;
    localparam logic [3:0] OP_OR   = 4'd4;
    localparam logic [3:0] OP_BEQ  = 4'd5;
    localparam logic [3:0] OP_LW   = 4'd8;
    localparam logic [3:0] OP_SW   = 4'd9;
    localparam logic [3:0] OP_ADDI = 4'd10;
    localparam logic [3:0] OP_SUBI = 4'd11;
    localparam logic [3:0] OP_BNE  = 4'd12;
    localparam logic [3:0] OP_HALT = 4'd15;

    // ALU operation codes
    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_OR  = 2'd3;

    // ALU B-operand selects
    localparam logic [1:0] SRCB_RT  = 2'd0;
    localparam logic [1:0] SRCB_ONE = 2'd1;
    localparam logic [1:0] SRCB_IMM = 2'd2;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_EXEC_R   = 4'd2,
        S_EXEC_I   = 4'd3,
        S_MEM_ADDR = 4'd4,
        S_MEM_RD   = 4'd5,
        S_MEM_WR   = 4'd6,
        S_WB_ALU   = 4'd7,
        S_WB_MEM   = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    typedef enum logic [2:0] {
        CL_R,
        CL_I,
        CL_MEM,
        CL_BR,
        CL_HALT,
        CL_ILL
    } op_class_t;

    // Datapath control word; field order is the port order of the top
    typedef struct packed {
        logic       pc_write;
        logic       pc_src;
        logic       ir_write;
        logic       i_or_d;
        logic       mem_req;
        logic       mem_we;
        logic       reg_write;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       halted;
        logic       illegal_op;
    } ctrl_t;

    function automatic op_class_t op_class(input logic [3:0] op);
        case (op)
            OP_ADD, OP_SUB, OP_AND, OP_OR: op_class = CL_R;
            OP_ADDI, OP_SUBI:              op_class = CL_I;
            OP_LW, OP_SW:                  op_class = CL_MEM;
            OP_BEQ, OP_BNE:                op_class = CL_BR;
            OP_HALT:                       op_class = CL_HALT;
            default:                       op_class = CL_ILL;
        endcase
    endfunction

    function automatic logic [1:0] alu_op_of(input logic [3:0] op);
        case (op)
            OP_SUB, OP_BEQ, OP_SUBI, OP_BNE: alu_op_of = ALU_SUB;
            OP_AND:                          alu_op_of = ALU_AND;
            OP_OR:                           alu_op_of = ALU_OR;
            default:                         alu_op_of = ALU_ADD;
        endcase
    endfunction

    // States that own a memory access and may stall on mem_ready
    function automatic logic is_mem_state(input state_t s);
        is_mem_state = (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
    endfunction

endpackage

// File: rtl/multicycle_control_fsm_mem_wait_timer.sv
// Memory wait counter with a sticky timeout flag. The count restarts on
// clear; once WAIT_MAX stalled cycles accumulate the flag sets and stays
// set until reset. WAIT_MAX of 0 turns the flag off entirely.
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic tick,
    output logic timeout
);

    localparam int CW = (WAIT_MAX < 2) ? 1 : $clog2(WAIT_MAX + 1);
    localparam logic            ENABLE   = (WAIT_MAX > 0);
    localparam logic [CW-1:0]   LIMIT    = CW'(WAIT_MAX);
    localparam logic [CW-1:0]   LIMIT_M1 = CW'((WAIT_MAX > 0) ? WAIT_MAX - 1 : 0);

    logic [CW-1:0] count;

    // Saturating stall counter; flag sets on the edge the count reaches the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count   <= '0;
            timeout <= 1'b0;
        end else if (clear) begin
            count <= '0;
        end else if (tick && ENABLE && count != LIMIT) begin
            count <= count + 1'b1;
            if (count == LIMIT_M1)
                timeout <= 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle sequencer for the 4-bit-opcode RISC core. Moore control word
// decoded from the state register; only the FETCH pc/ir loads, the branch
// pc_write and the DECODE illegal pulse look at live inputs.
module multicycle_control_fsm
    import multicycle_control_fsm_pkg::*;
#(
    parameter int M        = 4,
    parameter int WAIT_MAX = 15
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [M-1:0] opcode,
    input  logic         zero,
    input  logic         mem_ready,
    output logic         pc_write,
    output logic         pc_src,
    output logic         ir_write,
    output logic         i_or_d,
    output logic         mem_req,
    output logic         mem_we,
    output logic         reg_write,
    output logic         mem_to_reg,
    output logic         alu_src_a,
    output logic [1:0]   alu_src_b,
    output logic [1:0]   alu_op,
    output logic         halted,
    output logic         illegal_op,
    output logic         mem_timeout,
    output logic [3:0]   state_dbg
);

    state_t     state, state_next;
    logic [3:0] op_in;
    logic [3:0] op_q;
    ctrl_t      ctrl, ctrl_o;
    logic       timeout_q;
    logic       wait_clear, wait_tick;

    assign op_in = 4'(opcode);

    // Next-state selection; op_q carries the instruction past DECODE
    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:    if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (op_class(op_in))
                    CL_R:    state_next = S_EXEC_R;
                    CL_I:    state_next = S_EXEC_I;
                    CL_MEM:  state_next = S_MEM_ADDR;
                    CL_BR:   state_next = S_BRANCH;
                    CL_HALT: state_next = S_HALT;
                    default: state_next = S_FETCH;
                endcase
            end
            S_EXEC_R, S_EXEC_I: state_next = S_WB_ALU;
            S_MEM_ADDR: state_next = (op_q == OP_SW) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:   if (mem_ready) state_next = S_WB_MEM;
            S_MEM_WR:   if (mem_ready) state_next = S_FETCH;
            S_WB_ALU, S_WB_MEM, S_BRANCH: state_next = S_FETCH;
            S_HALT:     state_next = S_HALT;
            default:    state_next = S_FETCH;
        endcase
    end

    // State register and opcode latch
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_FETCH;
            op_q  <= 4'd0;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                op_q <= op_in;
        end
    end

    // Wait count restarts whenever a memory state is freshly entered
    assign wait_clear = is_mem_state(state_next) && (state_next != state);
    assign wait_tick  = is_mem_state(state) && !mem_ready;

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) u_wait (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (wait_clear),
        .tick    (wait_tick),
        .timeout (timeout_q)
    );

    // Control word per state; undefined encodings fall to all-zero
    always_comb begin
        ctrl = '0;
        case (state)
            S_FETCH: begin
                ctrl.mem_req   = 1'b1;
                ctrl.alu_src_b = SRCB_ONE;
                ctrl.alu_op    = ALU_ADD;
                ctrl.ir_write  = mem_ready;
                ctrl.pc_write  = mem_ready;
            end
            S_DECODE: ctrl.illegal_op = (op_class(op_in) == CL_ILL);
            S_EXEC_R: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = alu_op_of(op_q);
            end
            S_EXEC_I: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = alu_op_of(op_q);
            end
            S_MEM_ADDR: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_IMM;
                ctrl.alu_op    = ALU_ADD;
            end
            S_MEM_RD: begin
                ctrl.mem_req = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            S_MEM_WR: begin
                ctrl.mem_req = 1'b1;
                ctrl.mem_we  = 1'b1;
                ctrl.i_or_d  = 1'b1;
            end
            S_WB_ALU: ctrl.reg_write = 1'b1;
            S_WB_MEM: begin
                ctrl.reg_write  = 1'b1;
                ctrl.mem_to_reg = 1'b1;
            end
            S_BRANCH: begin
                ctrl.alu_src_a = 1'b1;
                ctrl.alu_src_b = SRCB_RT;
                ctrl.alu_op    = ALU_SUB;
                ctrl.pc_src    = 1'b1;
                ctrl.pc_write  = (op_q == OP_BNE) ? ~zero : zero;
            end
            S_HALT:  ctrl.halted = 1'b1;
            default: ctrl = '0;
        endcase
    end

    // Reset forces every output low without waiting for a clock
    assign ctrl_o = rst_n ? ctrl : '0;

    assign pc_write    = ctrl_o.pc_write;
    assign pc_src      = ctrl_o.pc_src;
    assign ir_write    = ctrl_o.ir_write;
    assign i_or_d      = ctrl_o.i_or_d;
    assign mem_req     = ctrl_o.mem_req;
    assign mem_we      = ctrl_o.mem_we;
    assign reg_write   = ctrl_o.reg_write;
    assign mem_to_reg  = ctrl_o.mem_to_reg;
    assign alu_src_a   = ctrl_o.alu_src_a;
    assign alu_src_b   = ctrl_o.alu_src_b;
    assign alu_op      = ctrl_o.alu_op;
    assign halted      = ctrl_o.halted;
    assign illegal_op  = ctrl_o.illegal_op;
    assign mem_timeout = rst_n & timeout_q;
    assign state_dbg   = rst_n ? 4'(state) : 4'd0;

endmodule
